alu_pipe: RTL
=============

// Module: alu_pipe
// PURPOSE
//  Parametrised, registered successor to the datapath ALU: WIDTH-bit operands, 3-bit op, N/Z/V/C status.
//  Valid/ready on both sides, so the datapath FSM can stall it and multi-cycle ops can be added.
//  Sits between the register-file operand latches (A/B) and the writeback/status registers.
//  Single-cycle ops return one cycle after accept; optional iterative multiply takes WIDTH+1 cycles.
// PARAMETERS
//  WIDTH   16   operand/result width in bits (>=4)
// PORTS
//  clk        in   1      rising-edge clock; single clock domain
//  reset      in   1      asynchronous, active-high reset
//  in_valid   in   1      operand/op presented
//  in_ready   out  1      block can accept this cycle
//  Ain        in   WIDTH  operand A
//  Bin        in   WIDTH  operand B
//  ALUop      in   3      operation (alu_pkg::alu_op_e)
//  out_valid  out  1      out/status hold a result
//  out_ready  in   1      consumer takes result this cycle
//  out        out  WIDTH  result
//  status     out  4      {N,V,C,Z} for result
// BEHAVIOUR
//  Ops: 000 ADD A+B; 001 SUB A-B; 010 AND; 011 NOT ~B; 100 OR; 101 XOR; 110 MUL (low WIDTH bits of A*B); 111 PASS B.
//  Codes 000-011 match the legacy 2-bit ALU encoding with ALUop[2]=0.
//  Accept = in_valid & in_ready. in_ready = (state==IDLE) & (!out_valid | out_ready).
//  Non-MUL op: result + flags registered on accept edge; out_valid=1 next cycle (latency 1).
//  out_valid/out/status hold stable until out_valid & out_ready; a new accept may occur in that same cycle (back-to-back, 1 result/cycle).
//  Z = (out==0). N = out[WIDTH-1].
//  C: ADD carry-out; SUB = no-borrow (carry of A+~B+1); 0 for all other ops.
//  V: ADD/SUB signed overflow (two's complement); 0 for all other ops.
//  FSM (alu_pkg::alu_state_e): IDLE, MUL.
//   IDLE --accept & op==MUL--> MUL (latch A,B; count=0).
//   MUL: one shift-add step per cycle, count++.
//   MUL --count==WIDTH-1--> IDLE, result registered, out_valid=1. Total latency WIDTH+1 cycles from accept (17 at WIDTH=16).
//  in_ready=0 throughout MUL; in_valid ignored there.
//  Wrap-around: all arithmetic modulo 2^WIDTH; MUL high half discarded.
//  Reset (any time, incl. mid-MUL): state=IDLE, count=0, out_valid=0, out=0, status=4'b0000; in_ready=1 after release.
//   Partial product discarded; no result emitted.
//  No X propagation: unused op paths drive 0.
// CONFIGURATION
//  ALU_PIPE_MUL_EN defined: op 110 executes iterative multiply as above.
//  Undefined: MUL FSM state and multiplier not built; op 110 completes in 1 cycle with out=0, status={0,0,0,1}.
// STRUCTURE
//  alu_pkg:
//   - alu_op_e (3-bit enum, codes above)
//   - alu_state_e {IDLE, MUL}
//   - status bit index localparams ST_Z=0, ST_C=1, ST_V=2, ST_N=3
//  Sub-module alu_mul_seq (WIDTH param): start/A/B in, busy/done/product out.
//   Instantiated only under ALU_PIPE_MUL_EN. Combinational op decode stays in alu_pipe.
// TESTING
//  1. WIDTH=16, ADD 0x7FFF+0x0001, out_ready=1 -> next cycle out=0x8000, status N=1,V=1,C=0,Z=0.
//  2. SUB 0x0005-0x0005 -> out=0x0000, Z=1,C=1,V=0.
//     SUB 0x0000-0x0001 -> out=0xFFFF, N=1,C=0.
//  3. NOT Bin=0xFFFF -> out=0x0000, Z=1.
//     Issue AND,OR,XOR on consecutive cycles with out_ready=1 -> three results on three consecutive cycles, in order.
//  4. Backpressure: out_ready=0 after ADD 3+4 -> out=7 held, in_ready=0 while held.
//     Raise out_ready -> handshake; new op accepted same cycle.
//  5. MUL_EN: MUL 0x0012*0x0034 -> out_valid exactly 17 cycles after accept, out=0x03A8.
//     0xFFFF*0xFFFF -> 0x0001. Without macro: MUL -> out=0, Z=1 after 1 cycle.
//  6. Assert reset at cycle 5 of a MUL -> out_valid=0, status=0, in_ready=1 after release.
//     Next ADD 1+1 -> out=2 after 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: op encoding, FSM states and status bit
// positions. Status is packed {N,V,C,Z} from bit 3 down to bit 0.
package alu_pkg;

    // Codes 000-011 are identical to the legacy 2-bit ALU encoding.
    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_NOT  = 3'b011,
        OP_OR   = 3'b100,
        OP_XOR  = 3'b101,
        OP_MUL  = 3'b110,
        OP_PASS = 3'b111
    } alu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_e;

    localparam int ST_Z = 0;
    localparam int ST_C = 1;
    localparam int ST_V = 2;
    localparam int ST_N = 3;

    // Pack individual flags into the status nibble at their fixed positions.
    function automatic logic [3:0] status_pack(input logic n, input logic v,
                                               input logic c, input logic z);
        logic [3:0] s;
        s       = 4'b0000;
        s[ST_N] = n;
        s[ST_V] = v;
        s[ST_C] = c;
        s[ST_Z] = z;
        return s;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial-product step per cycle.
// A start pulse latches the operands; after WIDTH steps 'done' pulses for one
// cycle with the low WIDTH bits of A*B on 'product' (high half is discarded).
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_count;
    logic             r_busy;
    logic             r_done;

    // Operand latch on start, then one shift-add step per busy cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_mcand  <= i_a;
                r_mplier <= i_b;
                r_acc    <= '0;
                r_count  <= '0;
                r_busy   <= 1'b1;
            end else if (r_busy) begin
                // Multiplicand shifts left modulo 2^WIDTH, so bits above
                // WIDTH never enter the accumulator.
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_count  <= r_count + 1'b1;
                if (r_count == CW'(WIDTH - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_product = r_acc;

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes on input and output.
// Single-cycle ops produce a result one cycle after accept; with the
// ALU_PIPE_MUL_EN macro defined, op MUL runs on an iterative multiplier and
// completes WIDTH+1 cycles after accept. Without the macro, MUL returns 0 in
// one cycle.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    input  logic [2:0]       ALUop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       status
);

    alu_op_e          w_op;
    logic             w_idle;
    logic             w_accept;
    logic             w_mul_start;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_product;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic [3:0]       w_flags;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out;
    logic [3:0]       r_status;

    assign w_op     = alu_op_e'(ALUop);
    assign in_ready = w_idle & (~r_out_valid | out_ready);
    assign w_accept = in_valid & in_ready;

    // SUB is A + ~B + 1 so that the carry-out is the no-borrow flag.
    assign w_add = {1'b0, Ain} + {1'b0, Bin};
    assign w_sub = {1'b0, Ain} + {1'b0, ~Bin} + (WIDTH + 1)'(1);

`ifdef ALU_PIPE_MUL_EN
    alu_state_e r_state;
    alu_state_e w_state_next;
    logic       w_mul_busy;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: leave IDLE on a MUL accept, return when the multiplier is done.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_mul_start) w_state_next = MUL;
            MUL:     if (w_mul_done)  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign w_idle      = (r_state == IDLE) & ~w_mul_busy;
    assign w_mul_start = w_accept & (w_op == OP_MUL);

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_mul_start),
        .i_a       (Ain),
        .i_b       (Bin),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );
`else
    assign w_idle        = 1'b1;
    assign w_mul_start   = 1'b0;
    assign w_mul_done    = 1'b0;
    assign w_mul_product = '0;
`endif

    // Single-cycle op decode; unused paths and MUL (handled elsewhere) give 0.
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_res = w_add[WIDTH-1:0];
                w_c   = w_add[WIDTH];
                w_v   = (Ain[WIDTH-1] == Bin[WIDTH-1]) &
                        (w_add[WIDTH-1] != Ain[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_sub[WIDTH-1:0];
                w_c   = w_sub[WIDTH];
                w_v   = (Ain[WIDTH-1] != Bin[WIDTH-1]) &
                        (w_sub[WIDTH-1] != Ain[WIDTH-1]);
            end
            OP_AND:  w_res = Ain & Bin;
            OP_NOT:  w_res = ~Bin;
            OP_OR:   w_res = Ain | Bin;
            OP_XOR:  w_res = Ain ^ Bin;
            OP_PASS: w_res = Bin;
            default: w_res = '0;
        endcase
        w_flags = status_pack(w_res[WIDTH-1], w_v, w_c, (w_res == '0));
    end

    // Output register: load on single-cycle accept or multiplier completion,
    // otherwise drop valid once the consumer has taken the result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_status    <= 4'b0000;
        end else begin
            if (w_accept && !w_mul_start) begin
                r_out       <= w_res;
                r_status    <= w_flags;
                r_out_valid <= 1'b1;
            end else if (w_mul_done) begin
                r_out       <= w_mul_product;
                r_status    <= status_pack(w_mul_product[WIDTH-1], 1'b0, 1'b0,
                                           (w_mul_product == '0));
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign status    = r_status;

endmodule
